// File: rtl/dmem_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface dmem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_stage.sv
// RV32I memory-access stage: load/store to request/ready bus with byte lanes and load formatting.
// Optional misaligned-access trap is enabled with `define DMEM_MISALIGN_TRAP_EN.
module dmem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [2:0]  funct3_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        misalign_m,
  dmem_if.master      dmem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        rd_valid_q;

  logic        access;
  logic        misaligned;
  logic        issue;
  logic [1:0]  offset;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign access = mem_read_m | mem_write_m;
  assign offset = alu_result_m[1:0];

  always_comb begin
    st_wdata = write_data_m;
    st_wstrb = 4'b1111;
    case (funct3_m)
      3'b000: begin
        st_wdata = {4{write_data_m[7:0]}};
        st_wstrb = 4'b0001 << offset;
      end
      3'b001: begin
        // Misaligned halves fall back to the half selected by offset[1].
        st_wdata = {2{write_data_m[15:0]}};
        st_wstrb = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = write_data_m;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    misaligned = 1'b0;
    if (funct3_m[1:0] == 2'b01)
      misaligned = offset[0];
    else if (funct3_m == 3'b010)
      misaligned = (offset != 2'b00);
  end

  assign misalign_m = mis_q;
`else
  assign misaligned = 1'b0;
  assign misalign_m = 1'b0;
`endif

  // Reset gates the combinational IDLE request so outputs drop without a clock edge.
  assign issue   = rst_n & (state == IDLE) & access & ~misaligned;
  assign stall_m = (rst_n & (state == IDLE) & access) | (state == BUSY);

  always_comb begin
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'd0;
    dmem.dmem_wdata = 32'd0;
    dmem.dmem_wstrb = 4'd0;
    if (issue) begin
      dmem.dmem_req   = 1'b1;
      dmem.dmem_we    = mem_write_m;
      dmem.dmem_addr  = {alu_result_m[31:2], 2'b00};
      dmem.dmem_wdata = mem_write_m ? st_wdata : 32'd0;
      dmem.dmem_wstrb = mem_write_m ? st_wstrb : 4'd0;
    end else if (state == BUSY) begin
      dmem.dmem_req   = 1'b1;
      dmem.dmem_we    = we_q;
      dmem.dmem_addr  = addr_q;
      dmem.dmem_wdata = wdata_q;
      dmem.dmem_wstrb = wstrb_q;
    end
  end

  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b100:  load_fmt = {24'd0, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b101:  load_fmt = {16'd0, h};
      default: load_fmt = word;
    endcase
  endfunction

  assign read_data_m = ((state == DONE) && rd_valid_q) ? load_fmt(rdata_q, off_q, f3_q) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      off_q      <= 2'd0;
      f3_q       <= 3'd0;
      rdata_q    <= 32'd0;
      rd_valid_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              state <= DONE;
`ifdef DMEM_MISALIGN_TRAP_EN
              mis_q <= 1'b1;
`endif
            end else begin
              addr_q  <= {alu_result_m[31:2], 2'b00};
              we_q    <= mem_write_m;
              wdata_q <= mem_write_m ? st_wdata : 32'd0;
              wstrb_q <= mem_write_m ? st_wstrb : 4'd0;
              off_q   <= offset;
              f3_q    <= funct3_m;
              if (dmem.dmem_ready) begin
                state <= DONE;
                if (!mem_write_m) begin
                  rdata_q    <= dmem.dmem_rdata;
                  rd_valid_q <= 1'b1;
                end
              end else begin
                state <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_ready) begin
            state <= DONE;
            if (!we_q) begin
              rdata_q    <= dmem.dmem_rdata;
              rd_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          rd_valid_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
          mis_q      <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_stage.sv
// Scoreboard bench for dmem_access_stage: directed accesses queue expected DONE-cycle results,
// a negedge monitor compares bus fields, stall length and formatted load data.
module tb_dmem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [2:0]  funct3_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [31:0] read_data_m;
  logic        stall_m;
  logic        misalign_m;

  dmem_if bus ();

  dmem_access_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .funct3_m     (funct3_m),
    .mem_read_m   (mem_read_m),
    .mem_write_m  (mem_write_m),
    .read_data_m  (read_data_m),
    .stall_m      (stall_m),
    .misalign_m   (misalign_m),
    .dmem         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stalls;
    logic [31:0] rdata_out;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic req, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int stalls, input logic [31:0] rdo, input logic mis);
    exp_t e;
    e.req = req; e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb;
    e.stalls = stalls; e.rdata_out = rdo; e.mis = mis;
    return e;
  endfunction

  // Monitor: records the first request cycle, checks request stability, and scores each DONE cycle.
  int          stall_cnt = 0;
  logic        req_seen  = 1'b0;
  logic [31:0] r_addr, r_wdata;
  logic        r_we;
  logic [3:0]  r_wstrb;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      req_seen  = 1'b0;
    end else begin
      if (bus.dmem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          r_addr = bus.dmem_addr; r_we = bus.dmem_we;
          r_wdata = bus.dmem_wdata; r_wstrb = bus.dmem_wstrb;
        end else begin
          chk("req_stable", {bus.dmem_addr ^ r_addr} | {31'd0, bus.dmem_we ^ r_we}
              | (r_we ? (bus.dmem_wdata ^ r_wdata) : 32'd0) | {28'd0, bus.dmem_wstrb ^ r_wstrb}, 32'd0);
        end
      end
      if (stall_m) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          txn++;
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("read_data_m", read_data_m, e.rdata_out);
          chk("misalign_m", {31'd0, misalign_m}, {31'd0, e.mis});
          chk("req_issued", {31'd0, req_seen}, {31'd0, e.req});
          chk("req_in_done", {31'd0, bus.dmem_req}, 32'd0);
          if (e.req && req_seen) begin
            chk("dmem_addr", r_addr, e.addr);
            chk("dmem_we", {31'd0, r_we}, {31'd0, e.we});
            if (e.we) chk("dmem_wdata", r_wdata, e.wdata);
            chk("dmem_wstrb", {28'd0, r_wstrb}, {28'd0, e.wstrb});
          end
          $display("txn %0d: addr=%h we=%b wdata=%h wstrb=%b stalls=%0d read_data=%h misalign=%b",
                   txn, r_addr, r_we, r_wdata, r_wstrb, stall_cnt, read_data_m, misalign_m);
        end
        stall_cnt = 0;
        req_seen  = 1'b0;
      end
    end
  end

  task automatic clear_inputs();
    mem_read_m = 1'b0; mem_write_m = 1'b0;
    alu_result_m = 32'd0; write_data_m = 32'd0; funct3_m = 3'd0;
  endtask

  // lat = number of stall cycles; dmem_ready rises in stall cycle number lat.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input int lat,
                        input logic [31:0] rdw, input exp_t e);
    int  cnt;
    bit  done;
    sb.push_back(e);
    mem_write_m = wr; mem_read_m = rd;
    alu_result_m = a; write_data_m = wd; funct3_m = f3;
    bus.dmem_rdata = rdw;
    cnt = 0;
    done = 1'b0;
    bus.dmem_ready = (lat <= 1);
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clk); #1;
      if (!stall_m) done = 1'b1;
      else begin
        cnt++;
        bus.dmem_ready = (cnt + 1 >= lat);
      end
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
    bus.dmem_ready = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_data", read_data_m, 32'd0);
    chk("rst_stall", {31'd0, stall_m}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_m}, 32'd0);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    mem_write_m = 1'b1; alu_result_m = 32'h100; funct3_m = 3'b010; write_data_m = 32'h1;
    #1;
    chk("rst_req_with_access", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_addr_with_access", bus.dmem_addr, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // dmem_ready while idle must be ignored
    bus.dmem_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_stall", {31'd0, stall_m}, 32'd0);
    chk("idle_ready_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("idle_ready_rdata", read_data_m, 32'd0);
    bus.dmem_ready = 1'b0;
    @(posedge clk); #1;

    access(1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 3, 32'h0,
           mk(1, 32'h100, 1, 32'hDEADBEEF, 4'b1111, 3, 32'h0, 0));
    access(1, 0, 32'h103, 32'h000000A5, 3'b000, 1, 32'h0,
           mk(1, 32'h100, 1, 32'hA5A5A5A5, 4'b1000, 1, 32'h0, 0));
    access(0, 1, 32'h102, 32'h0, 3'b000, 2, 32'h80FF7F01,
           mk(1, 32'h100, 0, 32'h0, 4'b0000, 2, 32'hFFFFFFFF, 0));
    access(0, 1, 32'h103, 32'h0, 3'b100, 1, 32'h80FF7F01,
           mk(1, 32'h100, 0, 32'h0, 4'b0000, 1, 32'h00000080, 0));
    access(0, 1, 32'h102, 32'h0, 3'b101, 2, 32'h80FF7F01,
           mk(1, 32'h100, 0, 32'h0, 4'b0000, 2, 32'h000080FF, 0));
    access(0, 1, 32'h100, 32'h0, 3'b001, 1, 32'h12348001,
           mk(1, 32'h100, 0, 32'h0, 4'b0000, 1, 32'hFFFF8001, 0));
    access(1, 0, 32'h106, 32'h0000BEEF, 3'b001, 2, 32'h0,
           mk(1, 32'h104, 1, 32'hBEEFBEEF, 4'b1100, 2, 32'h0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    access(0, 1, 32'h101, 32'h0, 3'b010, 1, 32'hCAFEF00D,
           mk(0, 32'h0, 0, 32'h0, 4'b0000, 1, 32'h0, 1));
`else
    access(0, 1, 32'h101, 32'h0, 3'b010, 1, 32'hCAFEF00D,
           mk(1, 32'h100, 0, 32'h0, 4'b0000, 1, 32'hCAFEF00D, 0));
`endif
    // both controls set: the store wins and no load data comes back
    access(1, 1, 32'h200, 32'h11223344, 3'b010, 1, 32'h99999999,
           mk(1, 32'h200, 1, 32'h11223344, 4'b1111, 1, 32'h0, 0));
    access(0, 1, 32'h204, 32'h0, 3'b010, 4, 32'h55AA55AA,
           mk(1, 32'h204, 0, 32'h0, 4'b0000, 4, 32'h55AA55AA, 0));

    // reset in the middle of a BUSY transaction
    mem_write_m = 1'b1; alu_result_m = 32'h300; write_data_m = 32'h12345678; funct3_m = 3'b010;
    bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_stall_before_rst", {31'd0, stall_m}, 32'd1);
    chk("busy_req_before_rst", {31'd0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall_m}, 32'd0);
    chk("midrst_addr", bus.dmem_addr, 32'd0);
    chk("midrst_wdata", bus.dmem_wdata, 32'd0);
    chk("midrst_wstrb_we", {27'd0, bus.dmem_we, bus.dmem_wstrb}, 32'd0);
    chk("midrst_rdata_mis", read_data_m | {31'd0, misalign_m}, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", {31'd0, stall_m}, 32'd0);

    access(0, 1, 32'h301, 32'h0, 3'b000, 2, 32'h0000F300,
           mk(1, 32'h300, 0, 32'h0, 4'b0000, 2, 32'hFFFFFFF3, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
